// File: rtl/hdmi_cfg_sequencer_pkg.sv
// Shared types and constants for the ADV7513 configuration sequencer.
//   cfg_state_e        : sequencer FSM states
//   ADV7513_SLAVE_ADDR : 7-bit slave address with the write bit appended
//   DEF_*              : default delays in CLK_I2C cycles (250 kHz)
package hdmi_cfg_pkg;

   typedef enum logic [2:0] {
      ST_PWRUP   = 3'd0,
      ST_ISSUE   = 3'd1,
      ST_WAIT    = 3'd2,
      ST_BACKOFF = 3'd3,
      ST_DONE    = 3'd4,
      ST_HPD     = 3'd5,
      ST_FAIL    = 3'd6
   } cfg_state_e;

   localparam logic [7:0] ADV7513_SLAVE_ADDR = 8'h72;

   localparam int unsigned DEF_NUM_OF_CONFIG = 14;
   localparam int unsigned DEF_PWRUP_CYCLES  = 50000;
   localparam int unsigned DEF_HPD_CYCLES    = 25000;
   localparam int unsigned DEF_RETRY_GAP     = 250;
   localparam int unsigned DEF_MAX_RETRY     = 3;

endpackage

// File: rtl/hdmi_cfg_sequencer_if.sv
// Byte-level I2C write handshake between the configuration sequencer and
// the I2C master.
//   i2c_req   : transfer request, held until i2c_done
//   i2c_slave : slave address byte
//   i2c_reg   : register byte
//   i2c_data  : data byte
//   i2c_done  : one-cycle end-of-transfer pulse
//   i2c_nack  : qualified by i2c_done, 1 = NACK
// master = sequencer side, slave = I2C master engine side.
interface hdmi_cfg_sequencer_if;
   logic       i2c_req;
   logic [7:0] i2c_slave;
   logic [7:0] i2c_reg;
   logic [7:0] i2c_data;
   logic       i2c_done;
   logic       i2c_nack;

   modport master (
      output i2c_req, i2c_slave, i2c_reg, i2c_data,
      input  i2c_done, i2c_nack
   );

   modport slave (
      input  i2c_req, i2c_slave, i2c_reg, i2c_data,
      output i2c_done, i2c_nack
   );
endinterface

// File: rtl/hdmi_cfg_sequencer_sync_edge.sv
// Two-flop synchroniser for an asynchronous input plus a history flop that
// yields a one-cycle rising-edge pulse in the clk domain.
//   clk     : destination clock
//   rst     : synchronous active-high reset, clears all three flops
//   async_i : asynchronous input pin
//   rise_o  : one-cycle pulse on a synchronised 0->1 transition
module sync_edge (
   input  logic clk,
   input  logic rst,
   input  logic async_i,
   output logic rise_o
);

   logic meta_q;
   logic sync_q;
   logic hist_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         meta_q <= 1'b0;
         sync_q <= 1'b0;
         hist_q <= 1'b0;
      end else begin
         meta_q <= async_i;
         sync_q <= meta_q;
         hist_q <= sync_q;
      end
   end

   assign rise_o = sync_q & ~hist_q;

endmodule

// File: rtl/hdmi_cfg_sequencer.sv
// Walks the ADV7513 configuration table onto the I2C write master, with
// power-up delay, NACK retry with back-off and full re-configuration after a
// hot-plug interrupt. ready_o releases the HDMI pixel controller.
//   clk           : CLK_I2C domain clock
//   rst           : synchronous active-high reset (shared with the I2C master)
//   hdmi_int_i    : asynchronous ADV7513 interrupt / hot-plug line
//   config_i      : table entry at config_addr_o, [15:8] reg, [7:0] data
//   config_addr_o : current table index
//   i2c           : request/done handshake to the I2C master
//   ready_o       : configuration complete
//   error_o       : retries exhausted on some entry
//
// state   | meaning
// PWRUP   | power-up delay after reset
// ISSUE   | latch table entry, raise request
// WAIT    | transfer in flight, outputs frozen
// BACKOFF | gap after a NACK before retrying the same entry
// DONE    | table written, ready high
// HPD     | settle delay after a hot-plug edge
// FAIL    | retries exhausted, error high
module hdmi_cfg_sequencer
   import hdmi_cfg_pkg::*;
#(
   parameter int unsigned NUM_OF_CONFIG  = DEF_NUM_OF_CONFIG,
   parameter int unsigned ADDR_WIDTH     = 4,
   parameter logic [7:0]  I2C_SLAVE_ADDR = ADV7513_SLAVE_ADDR,
   parameter int unsigned PWRUP_CYCLES   = DEF_PWRUP_CYCLES,
   parameter int unsigned HPD_CYCLES     = DEF_HPD_CYCLES,
   parameter int unsigned RETRY_GAP      = DEF_RETRY_GAP,
   parameter int unsigned MAX_RETRY      = DEF_MAX_RETRY,
   parameter int unsigned CTR_WIDTH      = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  hdmi_int_i,
   input  logic [15:0]           config_i,
   output logic [ADDR_WIDTH-1:0] config_addr_o,
   hdmi_cfg_sequencer_if.master  i2c,
   output logic                  ready_o,
   output logic                  error_o
);

   localparam int unsigned RETRY_W = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);

   localparam logic [CTR_WIDTH-1:0]  PWRUP_LOAD = CTR_WIDTH'(PWRUP_CYCLES - 1);
   localparam logic [CTR_WIDTH-1:0]  HPD_LOAD   = CTR_WIDTH'(HPD_CYCLES - 1);
   localparam logic [CTR_WIDTH-1:0]  GAP_LOAD   = CTR_WIDTH'(RETRY_GAP - 1);
   localparam logic [ADDR_WIDTH-1:0] LAST_ADDR  = ADDR_WIDTH'(NUM_OF_CONFIG - 1);
   localparam logic [RETRY_W-1:0]    RETRY_MAX  = RETRY_W'(MAX_RETRY);

   cfg_state_e            state_q;
   logic [CTR_WIDTH-1:0]  cnt_q;
   logic [ADDR_WIDTH-1:0] addr_q;
   logic [RETRY_W-1:0]    retry_q;
   logic                  req_q;
   logic [7:0]            reg_q;
   logic [7:0]            data_q;
   logic                  ready_q;
   logic                  error_q;
   logic                  hpd_pend_q;

   logic hpd_rise;
   logic hpd_evt;
   logic cnt_zero;
   logic do_restart;

   sync_edge u_hpd_sync (
      .clk     (clk),
      .rst     (rst),
      .async_i (hdmi_int_i),
      .rise_o  (hpd_rise)
   );

   assign hpd_evt  = hpd_rise | hpd_pend_q;
   assign cnt_zero = (cnt_q == '0);

   // A hot-plug restart is taken only where no transfer is in flight: from
   // DONE/FAIL, or on the cycle the current transfer completes.
   always_comb begin
      do_restart = 1'b0;
      case (state_q)
         ST_WAIT:          do_restart = i2c.i2c_done & hpd_evt;
         ST_DONE, ST_FAIL: do_restart = hpd_evt;
         default:          do_restart = 1'b0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= ST_PWRUP;
         cnt_q      <= PWRUP_LOAD;
         addr_q     <= '0;
         retry_q    <= '0;
         req_q      <= 1'b0;
         reg_q      <= 8'h00;
         data_q     <= 8'h00;
         ready_q    <= 1'b0;
         error_q    <= 1'b0;
         hpd_pend_q <= 1'b0;
      end else begin
         // Edges seen while the table is being written are remembered and
         // serviced later; HPD restarts its own settle timer instead.
         if (hpd_rise && (state_q inside {ST_PWRUP, ST_ISSUE, ST_WAIT, ST_BACKOFF}))
            hpd_pend_q <= 1'b1;

         case (state_q)
            ST_PWRUP, ST_BACKOFF: begin
               if (cnt_zero) state_q <= ST_ISSUE;
               else          cnt_q   <= cnt_q - CTR_WIDTH'(1);
            end

            ST_ISSUE: begin
               reg_q   <= config_i[15:8];
               data_q  <= config_i[7:0];
               req_q   <= 1'b1;
               state_q <= ST_WAIT;
            end

            ST_WAIT: begin
               if (i2c.i2c_done) begin
                  req_q <= 1'b0;
                  if (!i2c.i2c_nack) begin
                     retry_q <= '0;
                     if (addr_q == LAST_ADDR) begin
                        ready_q <= 1'b1;
                        state_q <= ST_DONE;
                     end else begin
                        addr_q  <= addr_q + ADDR_WIDTH'(1);
                        state_q <= ST_ISSUE;
                     end
                  end else if (retry_q == RETRY_MAX) begin
                     error_q <= 1'b1;
                     ready_q <= 1'b0;
                     state_q <= ST_FAIL;
                  end else begin
                     retry_q <= retry_q + RETRY_W'(1);
                     cnt_q   <= GAP_LOAD;
                     state_q <= ST_BACKOFF;
                  end
               end
            end

            ST_HPD: begin
               if (hpd_rise)      cnt_q   <= HPD_LOAD;
               else if (cnt_zero) state_q <= ST_ISSUE;
               else               cnt_q   <= cnt_q - CTR_WIDTH'(1);
            end

            ST_DONE, ST_FAIL: ;

            default: state_q <= ST_PWRUP;
         endcase

         // Overrides whatever the case above scheduled for these registers.
         if (do_restart) begin
            ready_q    <= 1'b0;
            error_q    <= 1'b0;
            addr_q     <= '0;
            retry_q    <= '0;
            hpd_pend_q <= 1'b0;
            cnt_q      <= HPD_LOAD;
            state_q    <= ST_HPD;
         end
      end
   end

   assign config_addr_o = addr_q;
   assign i2c.i2c_req   = req_q;
   assign i2c.i2c_slave = I2C_SLAVE_ADDR;
   assign i2c.i2c_reg   = reg_q;
   assign i2c.i2c_data  = data_q;
   assign ready_o       = ready_q;
   assign error_o       = error_q;

endmodule

// File: tb/tb_hdmi_cfg_sequencer.sv
module tb_hdmi_cfg_sequencer;

   localparam int unsigned P    = 8;
   localparam int unsigned N    = 3;
   localparam int unsigned GAP  = 4;
   localparam int unsigned MAXR = 3;
   localparam int unsigned HPDC = 5;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        hdmi_int = 1'b0;
   logic [15:0] cfg;
   logic [3:0]  addr;
   logic        ready;
   logic        error;
   logic [15:0] rom [16];

   int checks   = 0;
   int failures = 0;

   hdmi_cfg_sequencer_if bus ();

   always #5 clk = ~clk;

   assign cfg = rom[addr];

   hdmi_cfg_sequencer #(
      .NUM_OF_CONFIG (N),
      .ADDR_WIDTH    (4),
      .PWRUP_CYCLES  (P),
      .HPD_CYCLES    (HPDC),
      .RETRY_GAP     (GAP),
      .MAX_RETRY     (MAXR),
      .CTR_WIDTH     (16)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .hdmi_int_i    (hdmi_int),
      .config_i      (cfg),
      .config_addr_o (addr),
      .i2c           (bus),
      .ready_o       (ready),
      .error_o       (error)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic check_reset(input string tag);
      chk({tag, "_req"},   32'(bus.i2c_req),   32'd0);
      chk({tag, "_reg"},   32'(bus.i2c_reg),   32'd0);
      chk({tag, "_data"},  32'(bus.i2c_data),  32'd0);
      chk({tag, "_addr"},  32'(addr),          32'd0);
      chk({tag, "_ready"}, 32'(ready),         32'd0);
      chk({tag, "_error"}, 32'(error),         32'd0);
      chk({tag, "_slave"}, 32'(bus.i2c_slave), 32'h72);
   endtask

   // Idle cycles before the next request: one issue cycle, plus any delay
   // state (power-up, back-off, hot-plug settle) that precedes it.
   task automatic wait_req(input string tag, input int exp_wait);
      int n = 0;
      while (bus.i2c_req !== 1'b1 && n < 200) begin
         tick();
         n++;
      end
      chk(tag, 32'(n), 32'(exp_wait));
   endtask

   // Acts as the I2C master for one transfer of table entry idx.
   task automatic serve(input string tag, input logic [3:0] idx, input bit nack, input int lat_force);
      logic [15:0] e;
      int lat;
      e   = rom[idx];
      lat = (lat_force < 0) ? int'($urandom_range(0, 3)) : lat_force;
      chk({tag, "_addr"},  32'(addr),         32'(idx));
      chk({tag, "_reg"},   32'(bus.i2c_reg),  32'(e[15:8]));
      chk({tag, "_data"},  32'(bus.i2c_data), 32'(e[7:0]));
      chk({tag, "_flags"}, 32'({ready, error}), 32'd0);
      repeat (lat) begin
         tick();
         chk({tag, "_hold"}, 32'({bus.i2c_req, bus.i2c_reg, bus.i2c_data}), 32'({1'b1, e}));
      end
      bus.i2c_done = 1'b1;
      bus.i2c_nack = nack;
      tick();
      bus.i2c_done = 1'b0;
      bus.i2c_nack = 1'b0;
      chk({tag, "_drop"}, 32'(bus.i2c_req), 32'd0);
   endtask

   // Full table pass starting with the first request already up; nkX is the
   // number of NACKs given to entry X before it is acknowledged.
   task automatic run_seq(input string tag, input int nk0, input int nk1, input int nk2);
      int nk [3];
      nk[0] = nk0;
      nk[1] = nk1;
      nk[2] = nk2;
      for (int i = 0; i < 3; i++) begin
         for (int r = 0; r <= nk[i]; r++) begin
            if (i > 0 || r > 0) wait_req({tag, "_gap"}, (r > 0) ? int'(GAP + 1) : 1);
            serve(tag, 4'(i), r < nk[i], -1);
         end
      end
      chk({tag, "_ready"}, 32'(ready), 32'd1);
      chk({tag, "_error"}, 32'(error), 32'd0);
      chk({tag, "_last"},  32'(addr),  32'(N - 1));
   endtask

   task automatic hotplug(input string tag, input bit from_fail);
      int n = 0;
      hdmi_int = 1'b1;
      while (((from_fail ? error : ready) !== 1'b0) && n < 20) begin
         tick();
         n++;
      end
      chk({tag, "_fall"},  32'(n), 32'd3);
      chk({tag, "_flags"}, 32'({ready, error}), 32'd0);
      wait_req({tag, "_req"}, int'(HPDC + 1));
      hdmi_int = 1'b0;
   endtask

   initial begin
      int n;
      for (int i = 0; i < 16; i++) rom[4'(i)] = 16'hdead;
      rom[0] = 16'h1520;
      rom[1] = 16'h1630;
      rom[2] = 16'h1700;
      bus.i2c_done = 1'b0;
      bus.i2c_nack = 1'b0;

      repeat (3) tick();
      check_reset("rst");
      rst = 1'b0;

      // Normal run
      wait_req("pwrup", int'(P + 1));
      run_seq("normal", 0, 0, 0);
      repeat (4) begin
         tick();
         chk("done_idle", 32'({bus.i2c_req, ready, addr}), 32'({1'b0, 1'b1, 4'd2}));
      end

      // Hot-plug after DONE, then a single NACK on entry 1
      hotplug("hpd_done", 1'b0);
      run_seq("nack1", 0, 1, 0);

      // Retries exhausted on entry 0
      hotplug("hpd_pre_fail", 1'b0);
      for (int r = 0; r <= int'(MAXR); r++) begin
         if (r > 0) wait_req("fail_gap", int'(GAP + 1));
         serve("fail", 4'd0, 1'b1, -1);
      end
      chk("fail_error", 32'(error), 32'd1);
      chk("fail_ready", 32'(ready), 32'd0);
      n = 0;
      repeat (20) begin
         tick();
         if (bus.i2c_req === 1'b1) n++;
      end
      chk("fail_no_req", 32'(n), 32'd0);
      hotplug("hpd_fail", 1'b1);
      run_seq("after_fail", 0, 0, 0);

      // Hot-plug while entry 1 is in flight: the transfer completes first
      hotplug("hpd_pre_wait", 1'b0);
      serve("hpdw0", 4'd0, 1'b0, -1);
      wait_req("hpdw_gap", 1);
      hdmi_int = 1'b1;
      serve("hpdw1", 4'd1, 1'b0, 4);
      hdmi_int = 1'b0;
      wait_req("hpdw_req", int'(HPDC + 1));
      run_seq("hpdw_rerun", 0, 0, 0);

      // Randomized tables and NACK counts within the retry budget
      for (int k = 0; k < 3; k++) begin
         for (int i = 0; i < 3; i++) rom[4'(i)] = 16'($urandom);
         hotplug("hpd_rand", 1'b0);
         run_seq("rand", int'($urandom_range(0, MAXR)), int'($urandom_range(0, MAXR)),
                 int'($urandom_range(0, MAXR)));
      end

      // Reset in the middle of a transfer
      hotplug("hpd_pre_rst", 1'b0);
      tick();
      tick();
      rst = 1'b1;
      tick();
      check_reset("rst_mid");
      rst = 1'b0;
      wait_req("rst_pwrup", int'(P + 1));
      run_seq("after_rst", 0, 0, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
